// File: rtl/cpu_dma_rd_engine_pkg.sv
// cpu_dma_rd_engine_pkg: shared FSM state type, ctrl-to-byte-count constants and length width.
package cpu_dma_rd_engine_pkg;
  typedef enum logic [2:0] {IDLE, READ, DISCARD, DRAIN, DONE} state_t;
  localparam int LEN_W = 12;
  localparam logic [3:0] CTRL_B4 = 4'h1;
  localparam logic [3:0] CTRL_B3 = 4'h2;
  localparam logic [3:0] CTRL_B2 = 4'h4;
  localparam logic [3:0] CTRL_B1 = 4'h8;
  // Unrecognised nonzero ctrl is treated as a full word; the caller flags it as an error.
  function automatic logic [2:0] ctrl_bytes(input logic [3:0] ctrl);
    return ctrl == CTRL_B3 ? 3'd3 : ctrl == CTRL_B2 ? 3'd2 : ctrl == CTRL_B1 ? 3'd1 : 3'd4;
  endfunction
  function automatic logic ctrl_bad(input logic [3:0] ctrl);
    return !(ctrl inside {CTRL_B4, CTRL_B3, CTRL_B2, CTRL_B1});
  endfunction
endpackage

// File: rtl/cpu_dma_rd_engine_out_reg.sv
// cpu_dma_rd_out_reg: single-entry output register holding data stable until the host accepts it.
module cpu_dma_rd_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic [W-1:0] dout,
  output logic         vld,
  output logic         slot_free
);
  assign slot_free = !vld || rdy;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (rdy) begin
      vld  <= 1'b0;
    end
  end
endmodule

// File: rtl/cpu_dma_rd_engine.sv
// cpu_dma_rd_engine: drains one queued packet per host request to the host bus with length/error reporting.
// Optional statistics counters are built when CPU_DMA_RD_STATS_EN is defined.
module cpu_dma_rd_engine
  import cpu_dma_rd_engine_pkg::*;
#(
  parameter int DMA_DATA_WIDTH = 32,
  parameter int DMA_CTRL_WIDTH = 4,
  parameter int MAX_PKT_WORDS  = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_q_dma_pkt_avail,
  input  logic                      cpu_q_dma_rd_rdy,
  output logic                      cpu_q_dma_rd,
  input  logic [DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data,
  input  logic [DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
  input  logic                      host_xfer_req,
  output logic                      host_xfer_busy,
  output logic [DMA_DATA_WIDTH-1:0] host_data,
  output logic                      host_data_vld,
  input  logic                      host_data_rdy,
  output logic                      host_done,
  output logic [LEN_W-1:0]          host_len,
  output logic                      host_err,
  output logic [15:0]               stat_pkt_cnt,
  output logic [15:0]               stat_err_cnt
);
  state_t           state;
  logic [9:0]       word_cnt;
  logic [9:0]       cnt_inc;
  logic [LEN_W-1:0] len_r;
  logic             err_r;
  logic             slot_free;
  logic             load;
  logic             eop;
  logic [3:0]       ctrl4;
  assign ctrl4 = 4'(cpu_q_dma_rd_ctrl);
  assign eop = |cpu_q_dma_rd_ctrl;
  assign cpu_q_dma_rd = cpu_q_dma_rd_rdy && (state == DISCARD || (state == READ && slot_free));
  assign load = cpu_q_dma_rd && state == READ;
  assign cnt_inc = word_cnt == 10'(MAX_PKT_WORDS) ? word_cnt : word_cnt + 10'd1;
  assign host_xfer_busy = state != IDLE;

  cpu_dma_rd_out_reg #(.W(DMA_DATA_WIDTH)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .din       (cpu_q_dma_rd_data),
    .rdy       (host_data_rdy),
    .dout      (host_data),
    .vld       (host_data_vld),
    .slot_free (slot_free)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      len_r     <= '0;
      err_r     <= 1'b0;
      host_done <= 1'b0;
      host_len  <= '0;
      host_err  <= 1'b0;
    end else begin
      host_done <= 1'b0;
      case (state)
        IDLE: if (cpu_q_dma_pkt_avail && host_xfer_req) begin
          state    <= READ;
          word_cnt <= '0;
          len_r    <= '0;
          err_r    <= 1'b0;
        end
        READ: if (cpu_q_dma_rd) begin
          word_cnt <= cnt_inc;
          if (eop) begin
            state <= DRAIN;
            len_r <= (LEN_W'(word_cnt) << 2) + LEN_W'(ctrl_bytes(ctrl4));
            err_r <= ctrl_bad(ctrl4);
          end else if (cnt_inc == 10'(MAX_PKT_WORDS)) begin
            state <= DISCARD;
            len_r <= LEN_W'(4 * MAX_PKT_WORDS);
            err_r <= 1'b1;
          end
        end
        DISCARD: if (cpu_q_dma_rd && eop) state <= DRAIN;
        DRAIN: if (!host_data_vld) begin
          state     <= DONE;
          host_done <= 1'b1;
          host_len  <= len_r;
          host_err  <= err_r;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CPU_DMA_RD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_pkt_cnt <= '0;
      stat_err_cnt <= '0;
    end else if (host_done) begin
      stat_pkt_cnt <= stat_pkt_cnt + 16'd1;
      stat_err_cnt <= stat_err_cnt + 16'(host_err);
    end
  end
`else
  assign stat_pkt_cnt = '0;
  assign stat_err_cnt = '0;
`endif
endmodule

// File: tb/tb_cpu_dma_rd_engine.sv
// tb_cpu_dma_rd_engine: table-driven packet vectors plus reset/stall sequences against a FWFT queue model.
module tb_cpu_dma_rd_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pkt_avail = 1'b0, rd_rdy = 1'b0, rd;
  logic [31:0] rd_data = '0;
  logic [3:0]  rd_ctrl = '0;
  logic        req = 1'b0, busy;
  logic [31:0] hdata;
  logic        hvld, hrdy = 1'b1, hdone, herr;
  logic [11:0] hlen;
  logic [15:0] spkt, serr;

  cpu_dma_rd_engine dut (
    .clk(clk), .reset(reset), .cpu_q_dma_pkt_avail(pkt_avail), .cpu_q_dma_rd_rdy(rd_rdy),
    .cpu_q_dma_rd(rd), .cpu_q_dma_rd_data(rd_data), .cpu_q_dma_rd_ctrl(rd_ctrl),
    .host_xfer_req(req), .host_xfer_busy(busy), .host_data(hdata), .host_data_vld(hvld),
    .host_data_rdy(hrdy), .host_done(hdone), .host_len(hlen), .host_err(herr),
    .stat_pkt_cnt(spkt), .stat_err_cnt(serr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         words;
    logic [3:0] last_ctrl;
    bit         toggle;
    int         stall_at;
    logic [11:0] exp_len;
    bit         exp_err;
    int         exp_out;
  } vec_t;

  vec_t        vecs[8];
  int          checks = 0, failures = 0;
  int          cyc = 0, pops = 0, done_cnt = 0, stall_from = -100, stall_pops = 0;
  int          exp_pkts = 0, exp_errs = 0;
  bit          toggle = 0, last_pop = 0;
  logic [31:0] q_data[$];
  logic [3:0]  q_ctrl[$];
  logic [31:0] got[$];
  logic [11:0] last_len = '0;
  logic        last_err = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit stalled();
    return cyc >= stall_from && cyc < stall_from + 5;
  endfunction

  task automatic drive();
    pkt_avail = q_data.size() != 0;
    rd_rdy    = q_data.size() != 0 && !stalled();
    rd_data   = q_data.size() != 0 ? q_data[0] : 32'h0;
    rd_ctrl   = q_ctrl.size() != 0 ? q_ctrl[0] : 4'h0;
    hrdy      = toggle ? (cyc % 2 == 0) : 1'b1;
  endtask

  task automatic step();
    bit pop, acc, dn;
    logic [31:0] d;
    drive();
    #1;
    pop = rd;
    acc = hvld && hrdy;
    d = hdata;
    dn = hdone;
    if (pop && stalled()) stall_pops++;
    last_pop = pop;
    @(posedge clk);
    #1;
    cyc++;
    if (pop && q_data.size() != 0) begin
      void'(q_data.pop_front());
      void'(q_ctrl.pop_front());
    end
    if (pop) pops++;
    if (acc) got.push_back(d);
    if (dn) begin
      done_cnt++;
      last_len = hlen;
      last_err = herr;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int d0, bad;
    got.delete();
    pops = 0;
    d0 = done_cnt;
    for (int i = 0; i < v.words; i++) begin
      q_data.push_back({id[7:0], 24'(i)});
      q_ctrl.push_back(i == v.words - 1 ? v.last_ctrl : 4'h0);
    end
    toggle = v.toggle;
    stall_from = v.stall_at < 0 ? -100 : cyc + v.stall_at;
    stall_pops = 0;
    req = 1'b1;
    step();
    req = 1'b0;
    check($sformatf("pkt%0d_busy", id), busy, 1);
    for (int t = 0; t < 3000 && done_cnt == d0; t++) step();
    check($sformatf("pkt%0d_done_seen", id), done_cnt - d0, 1);
    step();
    step();
    check($sformatf("pkt%0d_done_pulse", id), done_cnt - d0, 1);
    check($sformatf("pkt%0d_busy_after", id), busy, 0);
    check($sformatf("pkt%0d_len", id), last_len, v.exp_len);
    check($sformatf("pkt%0d_err", id), last_err, v.exp_err);
    check($sformatf("pkt%0d_held_len", id), hlen, v.exp_len);
    check($sformatf("pkt%0d_words_out", id), got.size(), v.exp_out);
    bad = 0;
    for (int i = 0; i < got.size() && i < v.exp_out; i++)
      if (got[i] != {id[7:0], 24'(i)}) bad++;
    check($sformatf("pkt%0d_data_order", id), bad, 0);
    check($sformatf("pkt%0d_pops", id), pops, v.words);
    check($sformatf("pkt%0d_stall_pops", id), stall_pops, 0);
    check($sformatf("pkt%0d_queue_left", id), q_data.size(), 0);
    exp_pkts++;
    exp_errs += int'(v.exp_err);
    toggle = 0;
    stall_from = -100;
  endtask

  task automatic check_stats(input string name);
`ifdef CPU_DMA_RD_STATS_EN
    check({name, "_pkt_cnt"}, spkt, exp_pkts);
    check({name, "_err_cnt"}, serr, exp_errs);
`else
    check({name, "_pkt_cnt"}, spkt, 0);
    check({name, "_err_cnt"}, serr, 0);
`endif
  endtask

  initial begin
    int p0;
    vecs[0] = '{16,  4'h1, 0, -1, 12'd64,   0, 16};
    vecs[1] = '{16,  4'h8, 0, -1, 12'd61,   0, 16};
    vecs[2] = '{16,  4'h3, 0, -1, 12'd64,   1, 16};
    vecs[3] = '{16,  4'h2, 1,  6, 12'd63,   0, 16};
    vecs[4] = '{1,   4'h4, 0, -1, 12'd2,    0, 1};
    vecs[5] = '{600, 4'h1, 0, -1, 12'd2048, 1, 512};
    vecs[6] = '{512, 4'h1, 0, -1, 12'd2048, 0, 512};
    vecs[7] = '{3,   4'h1, 1, -1, 12'd12,   0, 3};

    drive();
    #12;
    check("rst_rd", rd, 0);
    check("rst_busy", busy, 0);
    check("rst_vld", hvld, 0);
    check("rst_done", hdone, 0);
    check("rst_len", hlen, 0);
    check("rst_err", herr, 0);
    check("rst_data", hdata, 0);
    check("rst_spkt", spkt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);
    check_stats("stats");

    for (int i = 0; i < 16; i++) begin
      q_data.push_back(32'hA000_0000 | i);
      q_ctrl.push_back(i == 15 ? 4'h1 : 4'h0);
    end
    got.delete();
    pops = 0;
    step();
    check("no_pop_without_req", pops, 0);
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    check("first_pop_first_read_cycle", last_pop, 1);
    for (int t = 0; t < 100 && pops < 7; t++) step();
    drive();
    #1;
    check("pre_reset_popping", rd, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_rd", rd, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vld", hvld, 0);
    check("mid_rst_data", hdata, 0);
    check("mid_rst_len", hlen, 0);
    check("mid_rst_err", herr, 0);
    check("mid_rst_spkt", spkt, 0);
    check("mid_rst_serr", serr, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    p0 = pops;
    for (int t = 0; t < 5; t++) step();
    check("no_pop_after_reset", pops - p0, 0);
    check("queue_keeps_partial", q_data.size(), 9);
    q_data.delete();
    q_ctrl.delete();
    exp_pkts = 0;
    exp_errs = 0;
    run_vec(vecs[0], 99);
    check_stats("stats_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_dma_rd_engine.md
# cpu_dma_rd_engine

DMA-side reader that drains packets from the CPU DMA queue's read interface (`cpu_q_dma_pkt_avail` / `cpu_q_dma_rd_*`) and streams them, one packet per host request, to the host bus master. It sits at the DMA end of the CPU queue, opposite the queue's read port. It tracks each packet's byte length, enforces a maximum length, and reports a completion descriptor per packet.

## Interface
- `DMA_DATA_WIDTH`, default 32: data word width.
- `DMA_CTRL_WIDTH`, default 4: ctrl width, DMA_DATA_WIDTH/8.
- `MAX_PKT_WORDS`, default 512: words forwarded before a packet is declared overlength.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low.
- `cpu_q_dma_pkt_avail`  in  1  at least one complete packet is queued.
- `cpu_q_dma_rd_rdy`  in  1  head word valid on `rd_data`/`rd_ctrl`.
- `cpu_q_dma_rd`  out  1  pop head word.
- `cpu_q_dma_rd_data`  in  32  head word, first-word-fall-through.
- `cpu_q_dma_rd_ctrl`  in  4  nonzero marks the last word of a packet.
- `host_xfer_req`  in  1  host requests one packet.
- `host_xfer_busy`  out  1  a packet transfer is in progress.
- `host_data`  out  32  output word.
- `host_data_vld`  out  1  `host_data` valid.
- `host_data_rdy`  in  1  host accepts the word.
- `host_done`  out  1  one-cycle completion pulse.
- `host_len`  out  12  packet byte length; held until the next `host_done`.
- `host_err`  out  1  packet error; held until the next `host_done`.
- `stat_pkt_cnt`  out  16  completed packets.
- `stat_err_cnt`  out  16  errored packets.

## Operation
- Reset values: all outputs 0, state IDLE, counters 0.
- **Queue interface.** The queue is first-word-fall-through: the head word and its ctrl are visible while `rd_rdy`=1, and `cpu_q_dma_rd` pops it in the same cycle.
- **Pop condition.** `cpu_q_dma_rd` = (state READ or DISCARD) & `rd_rdy` & (DISCARD | !`host_data_vld` | `host_data_rdy`).
- **IDLE.** Go to READ when `pkt_avail` & `host_xfer_req`. `host_xfer_req` is sampled only in IDLE.
- **READ.**
  - Each popped word loads the output register and increments `word_cnt`. `word_cnt` is 10 bits and saturates at MAX_PKT_WORDS.
  - A popped word with ctrl≠0 is the end of packet (EOP). On EOP, go to DRAIN.
  - When a non-EOP word makes `word_cnt` reach MAX_PKT_WORDS, set `err` and go to DISCARD.
- **DISCARD.** Pop words without forwarding until EOP, then go to DRAIN.
- **DRAIN.** Wait until `host_data_vld`=0, i.e. the last word has been accepted, then go to DONE.
- **DONE.** Pulse `host_done` for one cycle, latch `host_len` and `host_err`, then return to IDLE.
- **Length calculation.** Last-word valid bytes are MSB-first:
  - ctrl 0x1 → 4 bytes, 0x2 → 3, 0x4 → 2, 0x8 → 1.
  - Any other nonzero ctrl counts as 4 bytes and sets `err`.
  - Normal packet: `host_len` = 4·(words−1) + valid bytes.
  - Overlength packet: `host_len` = 4·MAX_PKT_WORDS = 2048.
- **Busy flag.** `host_xfer_busy` = state ≠ IDLE.
- **Stall.** If `rd_rdy` drops mid-packet, the engine holds its state and issues no pop.
- **Reset mid-packet.** All state clears immediately. The partially read packet stays in the queue; software resets the queue as well.

## Timing
- **Start.** IDLE→READ takes 1 cycle after `pkt_avail` & `host_xfer_req`. The first pop occurs in the first READ cycle, and `host_data_vld` rises the next cycle.
- **Throughput.** 1 word/cycle when `rd_rdy` and `host_data_rdy` are both 1.
- **Handshake.** `host_data` and `host_data_vld` are held stable while `host_data_vld`=1 and `host_data_rdy`=0.
- **Completion.** `host_done` is asserted 1 cycle after the cycle in which the last word is accepted, i.e. after the DRAIN exit.
- **Back-to-back packets.** Each packet requires a fresh `host_xfer_req` in IDLE. The minimum gap between packets is 2 cycles (DONE, IDLE).

## Configuration
- `CPU_DMA_RD_STATS_EN` defined: `stat_pkt_cnt` increments on every `host_done`; `stat_err_cnt` increments on every `host_done` with `host_err`=1. Both wrap at 16 bits.
- `CPU_DMA_RD_STATS_EN` undefined: no counters are built, and both stat outputs are tied to 0.

## Structure
- Shared package holds:
  - the state enum (IDLE, READ, DISCARD, DRAIN, DONE);
  - the ctrl-to-valid-bytes constants;
  - the 12-bit length width constant.
- One sub-module, `cpu_dma_rd_out_reg`: the single-entry output register with the valid/ready hold logic. It exports a `slot_free` signal to the pop condition.

## Test plan
- **Normal packet.** 64-byte packet, last ctrl 0x1, `host_data_rdy`=1 → 16 consecutive pops, 16 words out in order, `host_done` with `host_len`=64, `host_err`=0.
- **Partial last word.** 61-byte packet, last ctrl 0x8 → 16 words out, `host_len`=61. Repeat with last ctrl 0x3 → `host_len`=64, `host_err`=1.
- **Backpressure.** `host_data_rdy` toggling 1010…, plus `rd_rdy` low for 5 cycles mid-packet → no lost or duplicated words, and no pop during the stall.
- **Overlength.** 600-word packet, EOP on word 600 → 512 words forwarded, 88 popped and discarded, `host_len`=2048, `host_err`=1.
- **Reset mid-packet.** Reset low during word 8 → all outputs 0 immediately, state IDLE, no further pops until a new `host_xfer_req`.
- **Statistics.** With `CPU_DMA_RD_STATS_EN`, 3 good packets and 1 overlength packet → `stat_pkt_cnt`=4, `stat_err_cnt`=1. Without the macro → both outputs 0.
